// File: rtl/p18_sound_mixer.sv
// Multi-channel tone generator: per-channel square wave timed in VGA line pulses,
// note length in frames, mixed onto a single registered speaker bit.
module p18_sound_mixer #(
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 8,
    parameter int DUR_W    = 6,
    parameter int MIX_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         line_pulse,
    input  logic                         frame_pulse,
    input  logic [NUM_CH-1:0]            trig,
    input  logic [NUM_CH*PERIOD_W-1:0]   half_period,
    input  logic [NUM_CH*DUR_W-1:0]      duration,
    input  logic                         mute,
    output logic                         sound,
    output logic [NUM_CH-1:0]            ch_active,
    output logic                         busy
);

    logic [DUR_W-1:0]    dur_cnt [NUM_CH];
    logic [PERIOD_W-1:0] per_cnt [NUM_CH];
    logic [NUM_CH-1:0]   phase;

    logic [PERIOD_W-1:0] hp_fld  [NUM_CH];
    logic [DUR_W-1:0]    dur_fld [NUM_CH];
    logic                mix;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hp_fld[i]    = half_period[i*PERIOD_W +: PERIOD_W];
            dur_fld[i]   = duration[i*DUR_W +: DUR_W];
            ch_active[i] = (dur_cnt[i] != '0);
        end
    end

    assign busy = |ch_active;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        mix = 1'b0;
        if (MIX_MODE == 0) begin
            // Scan high to low so the lowest-index playing channel is written last.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (ch_active[i]) mix = phase[i];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                mix = mix | (phase[i] & ch_active[i]);
            end
        end
    end

    // NOTE: the per-channel counter arrays are plain flops, not RAM, so they take the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dur_cnt[i] <= '0;
                per_cnt[i] <= '0;
            end
            phase <= '0;
            sound <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (trig[i] && (dur_fld[i] != '0)) begin
                    // NOTE: non-blocking assignments keep every channel reading pre-edge state.
                    dur_cnt[i] <= dur_fld[i];
                    per_cnt[i] <= '0;
                    phase[i]   <= 1'b0;
                end else if (ch_active[i]) begin
                    if (frame_pulse && (dur_cnt[i] == DUR_W'(1))) begin
                        // Expiry outranks a coincident tone toggle.
                        dur_cnt[i] <= '0;
                        per_cnt[i] <= '0;
                        phase[i]   <= 1'b0;
                    end else begin
                        if (frame_pulse) dur_cnt[i] <= dur_cnt[i] - DUR_W'(1);
                        if (line_pulse) begin
                            if (hp_fld[i] == '0) begin
                                per_cnt[i] <= '0;
                                phase[i]   <= 1'b0;
                            end else if (per_cnt[i] == hp_fld[i] - PERIOD_W'(1)) begin
                                per_cnt[i] <= '0;
                                phase[i]   <= ~phase[i];
                            end else begin
                                per_cnt[i] <= per_cnt[i] + PERIOD_W'(1);
                            end
                        end
                    end
                end
            end
            sound <= mix & ~mute;
        end
    end

endmodule

// File: doc/p18_sound_mixer.md
Name: p18_sound_mixer

Overview:
- Parametrised successor to the single high/low beep generator in the breakout top level.
- Provides NUM_CH independent tone channels. Each channel has a programmable half-period, counted in VGA line pulses, and a programmable duration, counted in frames.
- A priority or OR mixer combines the channels onto one 1-bit speaker output.
- Sits beside the game logic: collision, block-break, life-lost and SPI-commanded effects each drive one trigger.

Parameters:
NUM_CH, 4, number of tone channels (1..8)
PERIOD_W, 8, width of per-channel half-period field, in line pulses
DUR_W, 6, width of per-channel duration field, in frames
MIX_MODE, 0, 0 = fixed priority (lowest index wins); 1 = logical OR of all active channel phases

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
line_pulse  in  1  one-cycle strobe per VGA line
frame_pulse  in  1  one-cycle strobe per VGA frame
trig  in  NUM_CH  per-channel start/retrigger strobe, sampled every cycle
half_period  in  NUM_CH*PERIOD_W  channel i in bits [i*PERIOD_W +: PERIOD_W]
duration  in  NUM_CH*DUR_W  channel i in bits [i*DUR_W +: DUR_W]
mute  in  1  forces the output low; counters keep running
sound  out  1  registered speaker output
ch_active  out  NUM_CH  channel i has nonzero remaining duration
busy  out  1  OR of ch_active

Behaviour:
- Reset (asynchronous, active-high) clears all of the following to 0: every duration counter, period counter and phase bit; sound; ch_active; busy.
- Per-channel state:
  - dur_cnt, DUR_W bits
  - per_cnt, PERIOD_W bits
  - phase, 1 bit
- Per-channel states: IDLE (dur_cnt = 0) and PLAYING (dur_cnt != 0). ch_active[i] is (dur_cnt != 0), combinational from the register.
- Trigger:
  - If trig[i] is high and duration field != 0: dur_cnt <= duration, per_cnt <= 0, phase <= 0. The channel enters or re-enters PLAYING.
  - Retrigger while PLAYING restarts the channel fully; there is no accumulation.
  - trig[i] with duration field = 0 is ignored; the channel state is unchanged.
- Duration:
  - In PLAYING, on frame_pulse with no trigger the same cycle: dur_cnt <= dur_cnt - 1.
  - The transition 1 -> 0 returns the channel to IDLE and clears phase and per_cnt.
  - Trigger and frame_pulse in the same cycle: trigger wins and the full duration is loaded.
- Tone:
  - In PLAYING, on line_pulse with no trigger: if per_cnt == half_period - 1, per_cnt <= 0 and phase toggles; otherwise per_cnt increments.
  - half_period = 0: phase is held at 0 (silent) but the channel still counts its duration.
  - half_period = 1: phase toggles every line pulse.
  - half_period changing mid-note takes effect on the next comparison.
  - If per_cnt already exceeds the new half_period - 1, per_cnt wraps through its maximum value; this is accepted behaviour.
- Mixer:
  - MIX_MODE 0: selects the phase of the lowest-index PLAYING channel. IDLE channels never mask higher-index channels.
  - MIX_MODE 1: OR of phase over PLAYING channels.
  - With no channel PLAYING the mix is 0.
- Output: sound <= mix & ~mute, registered. Latency is 1 clk from a phase change to sound.
- line_pulse and frame_pulse in the same cycle: both the period and duration updates apply. If the duration expires that cycle, the clear takes priority over the toggle.
- All counters are unsigned and there is no saturation logic; dur_cnt can never decrement below 0 because IDLE ignores frame_pulse.

Test Plan:
- Reset mid-note:
  - Stimulus: trigger ch0 with dur = 3, hp = 2; assert rst after 5 line pulses.
  - Required: sound, ch_active and busy are 0 immediately (asynchronously); the post-reset trig is honoured normally.
- Basic tone:
  - Stimulus: ch1 hp = 4, dur = 2; trig; line_pulse every 10 clk, frame_pulse every 100 clk.
  - Required: sound toggles every 4 line pulses, first rising edge 1 clk after the 4th line_pulse. ch_active[1] drops on the 2nd frame_pulse and sound is then 0.
- Priority:
  - Stimulus: MIX_MODE = 0; ch2 hp = 1 playing, then trig ch0 hp = 3.
  - Required: sound follows ch0 only while ch0 plays. After ch0 expires, sound follows ch2 again without any reset of ch2's phase.
- OR mode:
  - Stimulus: MIX_MODE = 1; ch0 hp = 2 and ch1 hp = 3 triggered together.
  - Required: sound = phase0 | phase1 each cycle (checked against a model); busy stays 1 until the longer duration expires.
- Boundaries:
  - Stimulus: trig with dur = 0.
  - Required: no state change.
  - Stimulus: hp = 0, dur = 1.
  - Required: ch_active = 1 for one frame while sound stays 0.
  - Stimulus: trig coincident with frame_pulse while dur_cnt = 1.
  - Required: dur_cnt reloads to the full duration and the channel does not drop out.
- Mute:
  - Stimulus: assert mute mid-note for 3 line pulses, then release.
  - Required: sound is 0 while mute is high. After release the phase continues, matching an un-muted reference model, with no restart.
